// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES inverse-cipher sequencer: one decryption round per clock through an external datapath.
// Optional feature: define AES_INV_BLK_CNT_EN to add the blk_count output (completed-block counter).
module aes_inv_round_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] cipher_in,
    output logic [3:0]   rk_idx,
    input  logic [0:127] rk_in,
    output logic [0:127] rd_state,
    output logic         rd_last,
    input  logic [0:127] rd_result,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef AES_INV_BLK_CNT_EN
    output logic [15:0]  blk_count,
`endif
    output logic [0:127] plain_out
);

    if (NR != 10 && NR != 12 && NR != 14) begin : g_nr_check
        $error("aes_inv_round_ctrl: NR must be 10, 12 or 14");
    end

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [3:0] NR_IDX     = 4'(NR);
    localparam logic [3:0] FIRST_ROUND = 4'(NR - 1);

    logic [1:0]   fsm_q;
    logic [0:127] state_q;
    logic [3:0]   round_q;

    // Every output is decoded from registered state only, so rk_in/rd_result
    // can never feed back combinationally into rk_idx, rd_state or rd_last.
    assign in_ready  = (fsm_q == S_IDLE);
    assign out_valid = (fsm_q == S_DONE);
    assign rk_idx    = (fsm_q == S_ROUND) ? round_q : NR_IDX;
    assign rd_last   = (fsm_q == S_ROUND) && (round_q == 4'd0);
    assign rd_state  = state_q;
    assign plain_out = state_q;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= S_IDLE;
            state_q <= '0;
            round_q <= '0;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    if (in_valid) begin
                        state_q <= cipher_in ^ rk_in;
                        round_q <= FIRST_ROUND;
                        fsm_q   <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    state_q <= rd_result;
                    if (round_q != 4'd0) begin
                        round_q <= round_q - 4'd1;
                    end else begin
                        fsm_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        fsm_q <= S_IDLE;
                    end
                end
                default: fsm_q <= S_IDLE;
            endcase
        end
    end

`ifdef AES_INV_BLK_CNT_EN
    logic [15:0] blk_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_count_q <= '0;
        end else if (out_valid && out_ready) begin
            blk_count_q <= blk_count_q + 16'd1;
        end
    end

    assign blk_count = blk_count_q;
`endif

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: NR=10 and NR=14 instances, each paired with an inverse-round
// datapath model and a FIPS-197 key-schedule store; a scoreboard checks plaintexts in order.
module tb_aes_inv_round_ctrl;

    localparam logic [255:0] KEY_A = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY_B = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY_C = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_C  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0]        in_valid, in_ready, rd_last, out_valid, out_ready;
    logic [1:0][127:0] cipher, rk_in, rd_state, rd_result, plain;
    logic [1:0][3:0]   rk_idx;
    logic [15:0]       blk_count10, blk_count14;
    logic              key_sel;

    logic [7:0]   sbox [256];
    logic [7:0]   isb  [256];
    logic [127:0] rk_a [0:15];
    logic [127:0] rk_b [0:15];
    logic [127:0] rk_c [0:15];
    logic [127:0] ks_tmp [0:15];

    logic [127:0] q0 [$];
    logic [127:0] q1 [$];
    logic [15:0]  blk_exp0;
    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    aes_inv_round_ctrl #(.NR(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .cipher_in(cipher[0]), .rk_idx(rk_idx[0]), .rk_in(rk_in[0]), .rd_state(rd_state[0]),
        .rd_last(rd_last[0]), .rd_result(rd_result[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]),
`ifdef AES_INV_BLK_CNT_EN
        .blk_count(blk_count10),
`endif
        .plain_out(plain[0])
    );

    aes_inv_round_ctrl #(.NR(14)) dut14 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .cipher_in(cipher[1]), .rk_idx(rk_idx[1]), .rk_in(rk_in[1]), .rd_state(rd_state[1]),
        .rd_last(rd_last[1]), .rd_result(rd_result[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]),
`ifdef AES_INV_BLK_CNT_EN
        .blk_count(blk_count14),
`endif
        .plain_out(plain[1])
    );

`ifndef AES_INV_BLK_CNT_EN
    assign blk_count10 = '0;
    assign blk_count14 = '0;
`endif

    // ---------------- AES reference helpers ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] x);
        return {x[6:0], x[7]};
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] key, input int nk, input int nr);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) ks_tmp[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last, input logic [7:0] t [256]);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [127:0] r;
        logic [7:0]   c0, c1, c2, c3;
        for (int i = 0; i < 16; i++) a[i] = s[127 - 8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++)
                b[rw + 4*c] = t[a[rw + 4*((c - rw + 4) % 4)]];
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = b[i];
        r = r ^ rk;
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                c0 = r[127 - 32*c -: 8];
                c1 = r[119 - 32*c -: 8];
                c2 = r[111 - 32*c -: 8];
                c3 = r[103 - 32*c -: 8];
                r[127 - 32*c -: 8] = gmul(c0,8'h0e) ^ gmul(c1,8'h0b) ^ gmul(c2,8'h0d) ^ gmul(c3,8'h09);
                r[119 - 32*c -: 8] = gmul(c0,8'h09) ^ gmul(c1,8'h0e) ^ gmul(c2,8'h0b) ^ gmul(c3,8'h0d);
                r[111 - 32*c -: 8] = gmul(c0,8'h0d) ^ gmul(c1,8'h09) ^ gmul(c2,8'h0e) ^ gmul(c3,8'h0b);
                r[103 - 32*c -: 8] = gmul(c0,8'h0b) ^ gmul(c1,8'h0d) ^ gmul(c2,8'h09) ^ gmul(c3,8'h0e);
            end
        end
        return r;
    endfunction

    // Key-schedule store lookup and round datapath for both instances.
    always_comb begin
        rk_in[0]     = key_sel ? rk_b[rk_idx[0]] : rk_a[rk_idx[0]];
        rk_in[1]     = rk_c[rk_idx[1]];
        rd_result[0] = inv_round(rd_state[0], rk_in[0], rd_last[0], isb);
        rd_result[1] = inv_round(rd_state[1], rk_in[1], rd_last[1], isb);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected at %0t", name, $time);
    endtask

    // Scoreboard monitor: pops one expected plaintext per output handshake.
    always @(negedge clk) begin : monitor
        logic [127:0] e;
        if (rst_n) begin
            if (out_valid[0] && out_ready[0]) begin
                if (q0.size() == 0) flag("plain10_unexpected");
                else begin
                    e = q0.pop_front();
                    check("plain10", plain[0], e);
                    blk_exp0 = blk_exp0 + 16'd1;
                end
            end
            if (out_valid[1] && out_ready[1]) begin
                if (q1.size() == 0) flag("plain14_unexpected");
                else begin
                    e = q1.pop_front();
                    check("plain14", plain[1], e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] ctrl(input int sel);
        return {rk_idx[sel], rd_last[sel], in_ready[sel], out_valid[sel]};
    endfunction

    task automatic push(input int sel, input logic [127:0] exp);
        if (sel == 0) q0.push_back(exp);
        else q1.push_back(exp);
    endtask

    task automatic send(input int sel, input logic [127:0] ct, input logic [127:0] exp, input bit do_push);
        int n = 0;
        in_valid[sel] = 1'b1;
        cipher[sel]   = ct;
        while (!in_ready[sel] && n < 50) begin step(); n++; end
        if (!in_ready[sel]) flag("accept_timeout");
        else if (do_push) push(sel, exp);
        step();
        in_valid[sel] = 1'b0;
    endtask

    task automatic wait_out(input int sel);
        int n = 0;
        while (!out_valid[sel] && n < 100) begin step(); n++; end
        if (!out_valid[sel]) flag("out_valid_timeout");
    endtask

    // Accept a block and trace rk_idx/rd_last every cycle up to out_valid.
    task automatic run_traced(input int sel, input logic [127:0] ct, input logic [127:0] exp, input int nr);
        int n = 0;
        in_valid[sel] = 1'b1;
        cipher[sel]   = ct;
        while (!in_ready[sel] && n < 50) begin step(); n++; end
        check("accept_cycle", ctrl(sel), {4'(nr), 1'b0, 1'b1, 1'b0});
        push(sel, exp);
        for (int k = nr - 1; k >= 0; k--) begin
            step();
            in_valid[sel] = 1'b0;
            check("round_trace", ctrl(sel), {4'(k), k == 0, 1'b0, 1'b0});
        end
        step();
        check("latency_out_valid", {in_ready[sel], out_valid[sel]}, 2'b01);
    endtask

    initial begin
        int cnt;
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv, s, x;
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            s = inv;
            x = inv;
            for (int i = 0; i < 4; i++) begin x = rotl1(x); s = s ^ x; end
            s = s ^ 8'h63;
            sbox[a] = s;
            isb[s]  = 8'(a);
        end
        expand(KEY_A, 4, 10);
        for (int r = 0; r <= 10; r++) rk_a[r] = ks_tmp[r];
        expand(KEY_B, 4, 10);
        for (int r = 0; r <= 10; r++) rk_b[r] = ks_tmp[r];
        expand(KEY_C, 8, 14);
        for (int r = 0; r <= 14; r++) rk_c[r] = ks_tmp[r];

        rst_n = 1'b0; in_valid = '0; out_ready = 2'b11; key_sel = 1'b0;
        cipher = '0; blk_exp0 = '0;
        #1;
        check("rst_ctrl10", ctrl(0), {4'd10, 1'b0, 1'b1, 1'b0});
        check("rst_ctrl14", ctrl(1), {4'd14, 1'b0, 1'b1, 1'b0});
        check("rst_plain10", plain[0], 128'h0);
        check("rst_plain14", plain[1], 128'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Basic NR=10 block with full trace.
        run_traced(0, CT_A, PT_A, 10);
        step();

        // Backpressure: hold out_ready low for 5 cycles in DONE.
        out_ready[0] = 1'b0;
        send(0, CT_A, PT_A, 1'b1);
        wait_out(0);
        for (int i = 0; i < 5; i++) begin
            check("bp_ctrl", {in_ready[0], out_valid[0]}, 2'b01);
            check("bp_plain_hold", plain[0], PT_A);
            step();
        end
        out_ready[0] = 1'b1;
        step();
        check("bp_release_idle", {in_ready[0], out_valid[0]}, 2'b10);

        // Busy: second block presented during ROUND must wait for the drain.
        send(0, CT_A, PT_A, 1'b1);
        step();
        in_valid[0] = 1'b1;
        cipher[0]   = CT_B;
        cnt = 0;
        while (!out_valid[0] && cnt < 50) begin
            check("busy_not_ready", in_ready[0], 1'b0);
            step();
            cnt++;
        end
        check("busy_done_no_ready", {in_ready[0], out_valid[0]}, 2'b01);
        key_sel = 1'b1;
        step();
        check("busy_accept_idle", in_ready[0], 1'b1);
        push(0, PT_B);
        step();
        in_valid[0] = 1'b0;
        check("busy_accepted", in_ready[0], 1'b0);
        wait_out(0);
        step();
`ifdef AES_INV_BLK_CNT_EN
        check("blk_count_4", blk_count10, blk_exp0);
`endif

        // Abort: reset while rk_idx == 5.
        send(0, CT_B, PT_B, 1'b0);
        cnt = 0;
        while (rk_idx[0] != 4'd5 && cnt < 20) begin step(); cnt++; end
        check("abort_at_rk5", rk_idx[0], 4'd5);
        rst_n = 1'b0;
        blk_exp0 = '0;
        #1;
        check("abort_rst_ctrl", ctrl(0), {4'd10, 1'b0, 1'b1, 1'b0});
        check("abort_rst_plain", plain[0], 128'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid[0]) cnt++;
            step();
        end
        check("abort_no_out", cnt, 0);
        run_traced(0, CT_B, PT_B, 10);
        step();
`ifdef AES_INV_BLK_CNT_EN
        check("blk_count_after_abort", blk_count10, blk_exp0);
        force dut10.blk_count_q = 16'hFFFF;
        blk_exp0 = 16'hFFFF;
        step();
        release dut10.blk_count_q;
        send(0, CT_A, PT_A, 1'b1);
        wait_out(0);
        step();
        check("blk_count_wrap", blk_count10, 16'h0000);
`endif

        // NR=14 instance.
        run_traced(1, CT_C, PT_C, 14);
        step();
        repeat (3) step();
        check("queues_drained", q0.size() + q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
